mul64: RTL and testbench
========================

// Module: mul64
// PURPOSE
// Sequential shift-and-add unsigned multiplier, a*b -> 2*WIDTH-bit product.
// Counterpart to the shift-subtract mod64 reducer: it uses the same en/rdy
// level handshake, so one user-domain controller drives both.
// One add per cycle, no DSP macros. Optional early exit when the multiplier runs out of set bits.
// PARAMETERS
// WIDTH       64  operand width; product is 2*WIDTH bits
// EARLY_EXIT  1   1: finish once the remaining multiplier bits are all zero; 0: always WIDTH iterations
// PORTS
// clk       in   1        clock, all logic on rising edge
// rst       in   1        synchronous, active-high reset
// en        in   1        start/hold request (level, same protocol as mod64)
// a         in   WIDTH    multiplicand, sampled on the start edge only
// b         in   WIDTH    multiplier, sampled on the start edge only
// busy      out  1        high while in RUN or RET_RESULT
// rdy       out  1        result valid; high only in READY
// prod_out  out  2*WIDTH  product, registered, held until the next RET_RESULT
// BEHAVIOUR
// - One clock (clk). Reset is synchronous and active-high (rst).
//   rst=1 at an edge: state=IDLE; rdy, busy, prod_out, mcand, mplier, acc and cnt all 0.
//   rst has priority over every other event, including mid-operation.
// - Registers:
//   mcand[2W] (multiplicand), mplier[W] (multiplier), acc[2W] (accumulator),
//   cnt[$clog2(WIDTH+1)] (iteration counter).
// - FSM: IDLE, RUN, RET_RESULT, READY.
// - IDLE & en (start edge k):
//   mcand<={W'0,a}; mplier<=b; acc<=0; cnt<=0; ->RUN. IDLE & !en: stay, rdy=0.
// - RUN, each edge:
//   if cnt==WIDTH, or (EARLY_EXIT && mplier==0): ->RET_RESULT with no register update.
//   Otherwise:
//     if mplier[0]: acc<=acc+mcand (mod 2^(2W); cannot overflow);
//     mcand<=mcand<<1; mplier<=mplier>>1; cnt<=cnt+1.
// - RET_RESULT: prod_out<=acc; rdy<=1; ->READY.
// - READY & en: hold, rdy=1. READY & !en: ->IDLE, rdy<=0 on that same edge.
// - Latency (rdy first seen high after edge): p = index of the highest set bit of b.
//   EARLY_EXIT=1: b==0 -> k+2; otherwise k+p+3.
//   EARLY_EXIT=0, or p==WIDTH-1: k+WIDTH+2 (66 for WIDTH=64).
// - en is ignored in RUN/RET_RESULT. Dropping en mid-operation does not abort:
//   the result completes, then READY with en=0 exits to IDLE on the next edge.
// - en held high across READY: no restart. A new start needs en low for at least one IDLE-entry edge.
// - a and b may change freely after edge k. prod_out is never cleared except by rst.
// - busy is a decode of the state (combinational from the state register); rdy is registered.
// TESTING
// 1 Reset: rst=1 for 2 edges with en=1 -> rdy=0, busy=0, prod_out=0, no start until rst=0.
// 2 a=3, b=5, en=1 at k -> rdy rises after edge k+5 (p=2), prod_out=15;
//   drop en -> rdy=0 after the next edge.
// 3 a=b=2^64-1 -> prod_out=0xFFFFFFFFFFFFFFFE_0000000000000001, rdy after edge k+66;
//   same latency for EARLY_EXIT=0 with b=1.
// 4 a=0x1234, b=0 -> prod_out=0, rdy after edge k+2; a=0, b=2^63 -> prod_out=0, rdy after k+66.
// 5 Drop en at k+10 with a=7, b=2^40 -> busy held to completion; prod_out=7*2^40;
//   one READY cycle, then IDLE.
// 6 Assert rst at k+20 mid-RUN -> IDLE with all outputs 0; a new start then gives a correct product.

Source files
------------

// File: rtl/mul64.sv
// Sequential shift-and-add unsigned multiplier producing a 2*WIDTH-bit product.
// Uses the same en/rdy level handshake as the shift-subtract mod64 reducer.
module mul64 #(
    parameter int WIDTH      = 64,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               rdy,
    output logic [2*WIDTH-1:0] prod_out
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_RET   = 2'd2;
    localparam logic [1:0] S_READY = 2'd3;

    logic [1:0]         state_q,  state_d;
    logic [2*WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q,    acc_d;
    logic [CW-1:0]      cnt_q,    cnt_d;
    logic               rdy_q,    rdy_d;
    logic [2*WIDTH-1:0] prod_q,   prod_d;

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        rdy_d    = rdy_q;
        prod_d   = prod_q;
        case (state_q)
            S_IDLE: begin
                rdy_d = 1'b0;
                if (en) begin
                    mcand_d  = {{WIDTH{1'b0}}, a};
                    mplier_d = b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                // Remaining multiplier bits all zero means acc already holds the product.
                if (cnt_q == CW'(WIDTH) || (EARLY_EXIT && mplier_q == '0)) begin
                    state_d = S_RET;
                end else begin
                    if (mplier_q[0]) acc_d = acc_q + mcand_q;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CW'(1);
                end
            end
            S_RET: begin
                prod_d  = acc_q;
                rdy_d   = 1'b1;
                state_d = S_READY;
            end
            default: begin
                if (!en) begin
                    rdy_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            rdy_q    <= 1'b0;
            prod_q   <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            rdy_q    <= rdy_d;
            prod_q   <= prod_d;
        end
    end

    assign busy     = (state_q == S_RUN) || (state_q == S_RET);
    assign rdy      = rdy_q;
    assign prod_out = prod_q;
endmodule

// File: tb/tb_mul64.sv
// Directed bench for mul64: drives an EARLY_EXIT=1 and an EARLY_EXIT=0 instance
// from the same stimulus and checks products and rdy latencies against a table.
module tb_mul64;
    typedef struct {
        logic [63:0]  a;
        logic [63:0]  b;
        logic [127:0] prod;
        int           lat1;
        int           lat0;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst, en;
    logic [63:0]  a, b;
    logic         busy1, rdy1, busy0, rdy0;
    logic [127:0] prod1, prod0;
    logic [127:0] prev_prod;
    int           checks = 0;
    int           errors = 0;
    vec_t         vecs[8];

    mul64 #(.WIDTH(64), .EARLY_EXIT(1'b1)) dut (
        .clk(clk), .rst(rst), .en(en), .a(a), .b(b),
        .busy(busy1), .rdy(rdy1), .prod_out(prod1)
    );
    mul64 #(.WIDTH(64), .EARLY_EXIT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .a(a), .b(b),
        .busy(busy0), .rdy(rdy0), .prod_out(prod0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    // Start at the next edge (k), report the first edge index j (k+j) that shows rdy.
    task automatic run_vec(input vec_t v, input string name);
        int  l1, l0;
        bit  g1, g0;
        l1 = -1; l0 = -1; g1 = 0; g0 = 0;
        @(negedge clk);
        a = v.a; b = v.b; en = 1'b1;
        for (int j = 0; j < 80 && !(g1 && g0); j++) begin
            edge_sample();
            if (j == 1) begin
                chk({name, " prod_held1"}, prod1, prev_prod);
                chk({name, " prod_held0"}, prod0, prev_prod);
                a = ~v.a; b = ~v.b;
            end
            if (!g1 && rdy1) begin g1 = 1; l1 = j; end
            if (!g0 && rdy0) begin g0 = 1; l0 = j; end
        end
        chk({name, " lat_ee1"}, 128'(l1), 128'(v.lat1));
        chk({name, " lat_ee0"}, 128'(l0), 128'(v.lat0));
        chk({name, " prod_ee1"}, prod1, v.prod);
        chk({name, " prod_ee0"}, prod0, v.prod);
        chk({name, " rdy_hold"}, {126'd0, rdy1, rdy0}, 128'd3);
        @(negedge clk);
        en = 1'b0;
        edge_sample();
        chk({name, " exit"}, {124'd0, rdy1, busy1, rdy0, busy0}, 128'd0);
        chk({name, " prod_kept"}, prod1, v.prod);
        prev_prod = v.prod;
    endtask

    initial begin
        int bad;
        vecs[0] = '{64'd3, 64'd5, 128'd15, 5, 66};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                    128'hFFFFFFFFFFFFFFFE_0000000000000001, 66, 66};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 128'hFFFF_FFFF_FFFF_FFFF, 3, 66};
        vecs[3] = '{64'h1234, 64'd0, 128'd0, 2, 66};
        vecs[4] = '{64'd0, 64'h8000_0000_0000_0000, 128'd0, 66, 66};
        vecs[5] = '{64'hDEAD_BEEF, 64'h10, 128'hD_EADB_EEF0, 7, 66};
        vecs[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 128'h1_FFFF_FFFF_FFFF_FFFE, 4, 66};
        vecs[7] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001,
                    128'h4000000000000000_8000000000000000, 66, 66};

        // Reset with en held high: nothing may start.
        rst = 1'b1; en = 1'b1; a = 64'd3; b = 64'd5;
        edge_sample();
        edge_sample();
        chk("reset_flags", {124'd0, rdy1, busy1, rdy0, busy0}, 128'd0);
        chk("reset_prod1", prod1, 128'd0);
        chk("reset_prod0", prod0, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        edge_sample();
        chk("start_after_rst", {126'd0, busy1, busy0}, 128'd3);
        @(negedge clk);
        rst = 1'b1; en = 1'b0;
        edge_sample();
        chk("rerst_flags", {124'd0, rdy1, busy1, rdy0, busy0}, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        prev_prod = '0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Drop en mid-run: both instances must complete, show one READY cycle, then idle.
        @(negedge clk);
        a = 64'd7; b = 64'h100_0000_0000; en = 1'b1;
        bad = 0;
        for (int j = 0; j <= 67; j++) begin
            edge_sample();
            if (j == 10) en = 1'b0;
            if (busy1 !== (j < 43)) bad++;
            if (rdy1  !== (j == 43)) bad++;
            if (busy0 !== (j < 66)) bad++;
            if (rdy0  !== (j == 66)) bad++;
        end
        chk("drop_en_seq", 128'(bad), 128'd0);
        chk("drop_en_prod1", prod1, 128'h700_0000_0000);
        chk("drop_en_prod0", prod0, 128'h700_0000_0000);

        // Reset mid-run, then a fresh start must still give a correct product.
        @(negedge clk);
        a = '1; b = '1; en = 1'b1;
        for (int j = 0; j <= 20; j++) edge_sample();
        chk("midrun_busy", {126'd0, busy1, busy0}, 128'd3);
        rst = 1'b1;
        edge_sample();
        chk("midrst_flags", {124'd0, rdy1, busy1, rdy0, busy0}, 128'd0);
        chk("midrst_prod1", prod1, 128'd0);
        chk("midrst_prod0", prod0, 128'd0);
        rst = 1'b0; en = 1'b0;
        prev_prod = '0;
        run_vec(vecs[0], "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
